// File: rtl/csrng_pkg.sv
// CSRNG shared definitions used by EDN endpoint logic.
package csrng_pkg;

  // Width of one CSRNG genbits block.
  parameter int unsigned GENBITS_BUS_WIDTH = 128;

endpackage

// File: rtl/edn_pkg.sv
// EDN endpoint request/response types shared by EDN and its requesters.
package edn_pkg;

  // Width of one endpoint word.
  parameter int unsigned ENDPOINT_BUS_WIDTH = 32;

  typedef struct packed {
    logic edn_req;
  } edn_req_t;

  typedef struct packed {
    logic                          edn_ack;
    logic                          edn_fips;
    logic [ENDPOINT_BUS_WIDTH-1:0] edn_bus;
  } edn_rsp_t;

endpackage

// File: rtl/edn_ep_rsp.sv
// EDN endpoint responder: buffers one genbits block and serves it one word per
// req/ack handshake, lowest word first.
module edn_ep_rsp
  import edn_pkg::*;
#(
  parameter int unsigned GenBitsWidth = csrng_pkg::GENBITS_BUS_WIDTH,
  parameter int unsigned BusWidth     = edn_pkg::ENDPOINT_BUS_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    genbits_valid_i,
  input  logic [GenBitsWidth-1:0] genbits_i,
  input  logic                    genbits_fips_i,
  output logic                    genbits_ready_o,
  input  edn_req_t                edn_i,
  output edn_rsp_t                edn_o,
  output logic                    buf_empty_o
);

  localparam int unsigned Words = GenBitsWidth / BusWidth;
  localparam int unsigned CntW  = $clog2(Words + 1);

  logic [GenBitsWidth-1:0] buf_q, buf_d;
  logic                    fips_buf_q, fips_buf_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    ack_q, ack_d;
  logic [BusWidth-1:0]     bus_q, bus_d;
  logic                    fips_q, fips_d;

  logic load;
  logic take;

  // Ready depends only on registered state and the enable, never on edn_req.
  assign genbits_ready_o = en_i && (cnt_q == '0);
  assign buf_empty_o     = (cnt_q == '0);
  assign load            = genbits_valid_i && genbits_ready_o;
  // Ignoring req while an ack is out prevents a lingering req from being served twice.
  assign take            = edn_i.edn_req && en_i && (cnt_q != '0) && !ack_q;

  // Next-state: disable flush, block load, word unpack and response capture.
  always_comb begin
    buf_d      = buf_q;
    fips_buf_d = fips_buf_q;
    cnt_d      = cnt_q;
    ack_d      = take;
    bus_d      = bus_q;
    fips_d     = fips_q;

    if (take) begin
      bus_d  = buf_q[BusWidth-1:0];
      fips_d = fips_buf_q;
    end

    if (!en_i) begin
      cnt_d = '0;
    end else if (load) begin
      buf_d      = genbits_i;
      fips_buf_d = genbits_fips_i;
      cnt_d      = CntW'(Words);
    end else if (take) begin
      buf_d = buf_q >> BusWidth;
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // State registers; reset aborts any ack pulse and clears the bus.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      buf_q      <= '0;
      fips_buf_q <= 1'b0;
      cnt_q      <= '0;
      ack_q      <= 1'b0;
      bus_q      <= '0;
      fips_q     <= 1'b0;
    end else begin
      buf_q      <= buf_d;
      fips_buf_q <= fips_buf_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      bus_q      <= bus_d;
      fips_q     <= fips_d;
    end
  end

  assign edn_o.edn_ack  = ack_q;
  assign edn_o.edn_fips = fips_q;
  assign edn_o.edn_bus  = bus_q;

  // A block must unpack into a whole number of words.
  a_width_multiple : assert property (@(posedge clk_i) (GenBitsWidth % BusWidth) == 0);

  // Ack is a single-cycle pulse.
  a_ack_pulse : assert property (@(posedge clk_i) disable iff (!rst_ni) ack_q |=> !ack_q);

endmodule

// File: tb/tb_edn_ep_rsp.sv
// Self-checking bench for edn_ep_rsp against a word-queue reference model.
module tb_edn_ep_rsp;
  import edn_pkg::*;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         en_i;
  logic         genbits_valid_i;
  logic [127:0] genbits_i;
  logic         genbits_fips_i;
  logic         genbits_ready_o;
  edn_req_t     edn_i;
  edn_rsp_t     edn_o;
  logic         buf_empty_o;

  always #5 clk_i = ~clk_i;

  edn_ep_rsp dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .en_i            (en_i),
    .genbits_valid_i (genbits_valid_i),
    .genbits_i       (genbits_i),
    .genbits_fips_i  (genbits_fips_i),
    .genbits_ready_o (genbits_ready_o),
    .edn_i           (edn_i),
    .edn_o           (edn_o),
    .buf_empty_o     (buf_empty_o)
  );

  // Reference model: undelivered words with their fips flag, plus the last response.
  logic [31:0] m_words[$];
  logic        m_fipsq[$];
  logic        m_ack;
  logic [31:0] m_bus;
  logic        m_fips;

  // Producer blocks waiting to be offered, and requester control.
  logic [127:0] blk_q[$];
  logic         blk_f[$];
  int           reqs_left;
  bit           hold_extra;
  bit           holding;

  int checks;
  int errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_block(input logic [127:0] data, input logic fips);
    blk_q.push_back(data);
    blk_f.push_back(fips);
  endtask

  function automatic logic [127:0] rand_block();
    logic [127:0] b;
    b = {$urandom(), $urandom(), $urandom(), $urandom()};
    return b;
  endfunction

  // One clock cycle: offer a block, update the model at the edge, check at the negedge,
  // then let the requester react to what it saw.
  task automatic step();
    logic rdy;
    logic take;
    logic [127:0] blk;
    genbits_valid_i = (blk_q.size() != 0);
    if (blk_q.size() != 0) begin
      genbits_i      = blk_q[0];
      genbits_fips_i = blk_f[0];
    end
    @(posedge clk_i);
    rdy  = en_i && (m_words.size() == 0);
    take = edn_i.edn_req && en_i && (m_words.size() != 0) && !m_ack;
    m_ack = take;
    if (take) begin
      m_bus  = m_words.pop_front();
      m_fips = m_fipsq.pop_front();
    end
    if (!en_i) begin
      m_words.delete();
      m_fipsq.delete();
    end else if (genbits_valid_i && rdy) begin
      blk = blk_q.pop_front();
      for (int i = 0; i < 4; i++) begin
        m_words.push_back(blk[i*32 +: 32]);
        m_fipsq.push_back(blk_f[0]);
      end
      void'(blk_f.pop_front());
    end
    @(negedge clk_i);
    chk("edn_ack", 32'(edn_o.edn_ack), 32'(m_ack));
    chk("edn_bus", edn_o.edn_bus, m_bus);
    chk("edn_fips", 32'(edn_o.edn_fips), 32'(m_fips));
    chk("genbits_ready", 32'(genbits_ready_o), 32'(en_i && (m_words.size() == 0)));
    chk("buf_empty", 32'(buf_empty_o), 32'(m_words.size() == 0));
    if (edn_o.edn_ack) begin
      reqs_left--;
      if (hold_extra) begin
        holding = 1'b1;
      end else begin
        edn_i.edn_req = 1'b0;
      end
    end else if (holding) begin
      holding       = 1'b0;
      edn_i.edn_req = 1'b0;
    end else if (reqs_left > 0) begin
      edn_i.edn_req = 1'b1;
    end
  endtask

  task automatic run_reqs(input string tag);
    int n = 0;
    while (reqs_left > 0 && n < 300) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(reqs_left), 32'd0);
    step();
    step();
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_ni = 1'b0; en_i = 1'b0; genbits_valid_i = 1'b0; genbits_i = '0;
    genbits_fips_i = 1'b0; edn_i.edn_req = 1'b0;
    m_ack = 1'b0; m_bus = '0; m_fips = 1'b0;
    reqs_left = 0; hold_extra = 1'b0; holding = 1'b0;

    // Reset values.
    #12;
    chk("rst_ack", 32'(edn_o.edn_ack), 32'd0);
    chk("rst_bus", edn_o.edn_bus, 32'd0);
    chk("rst_fips", 32'(edn_o.edn_fips), 32'd0);
    chk("rst_empty", 32'(buf_empty_o), 32'd1);
    chk("rst_ready_dis", 32'(genbits_ready_o), 32'd0);
    en_i = 1'b1;
    #1;
    chk("rst_ready_en", 32'(genbits_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Request with no block stalls.
    edn_i.edn_req = 1'b1;
    reqs_left = 4;
    repeat (10) step();

    // Known block arrives while the request is pending.
    add_block(128'h44444444_33333333_22222222_11111111, 1'b1);
    run_reqs("known_block");

    // Two back-to-back blocks with different fips.
    add_block(rand_block(), 1'b0);
    add_block(rand_block(), 1'b1);
    reqs_left = 8;
    run_reqs("two_blocks");

    // Requester lingers one cycle after each ack.
    hold_extra = 1'b1;
    add_block(rand_block(), 1'b1);
    reqs_left = 4;
    run_reqs("hold_extra");
    hold_extra = 1'b0;

    // Disable after two words, then re-enable with a new block.
    add_block(rand_block(), 1'b0);
    reqs_left = 2;
    run_reqs("pre_disable");
    en_i = 1'b0;
    reqs_left = 4;
    repeat (6) step();
    en_i = 1'b1;
    repeat (3) step();
    add_block(rand_block(), 1'b1);
    run_reqs("re_enable");

    // Randomized traffic with occasional disables.
    for (int c = 0; c < 400; c++) begin
      en_i = ($urandom_range(0, 24) != 0);
      if (blk_q.size() < 2 && $urandom_range(0, 3) == 0) add_block(rand_block(), 1'($urandom()));
      if (reqs_left == 0 && $urandom_range(0, 2) == 0) reqs_left = 1;
      if (!holding && !edn_i.edn_req) hold_extra = 1'($urandom());
      step();
    end
    en_i = 1'b1;
    hold_extra = 1'b0;
    run_reqs("random_drain");

    // Reset during an ack pulse.
    blk_q.delete(); blk_f.delete();
    reqs_left = 0;
    repeat (2) step();
    add_block(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_A5A5A5A5, 1'b1);
    reqs_left = 1;
    begin
      int n = 0;
      while (!edn_o.edn_ack && n < 50) begin
        step();
        n++;
      end
    end
    chk("pre_rst_ack", 32'(edn_o.edn_ack), 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_ack", 32'(edn_o.edn_ack), 32'd0);
    chk("mid_rst_bus", edn_o.edn_bus, 32'd0);
    chk("mid_rst_fips", 32'(edn_o.edn_fips), 32'd0);
    chk("mid_rst_empty", 32'(buf_empty_o), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/edn_ep_rsp.md
# edn_ep_rsp

EDN endpoint responder: the EDN-side server for one endpoint port. It accepts 128-bit entropy blocks with a FIPS flag from the CSRNG genbits interface and unpacks each block into four 32-bit words. It serves one word per request on the EDN req/ack interface, so a single source can feed any endpoint requester. It sits inside EDN, one instance per endpoint, in the EDN clock domain.

## Interface
Parameters:
- GenBitsWidth, 128, width of one entropy block; must be an integer multiple of BusWidth.
- BusWidth, edn_pkg::ENDPOINT_BUS_WIDTH (32), width of one endpoint word.

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  reset; asynchronous, active-low.
- en_i  input  1  endpoint enable; low flushes the buffer and suppresses acks.
- genbits_valid_i  input  1  entropy block valid.
- genbits_i  input  GenBitsWidth  entropy block.
- genbits_fips_i  input  1  block generated from a FIPS-approved seed.
- genbits_ready_o  output  1  block accepted when valid && ready.
- edn_i  input  edn_pkg::edn_req_t  endpoint request (edn_req).
- edn_o  output  edn_pkg::edn_rsp_t  endpoint response (edn_ack, edn_fips, edn_bus).
- buf_empty_o  output  1  no undelivered words in the buffer.

## Operation
- Words = GenBitsWidth/BusWidth (4). Word counter cnt_q has width $clog2(Words+1) and ranges 0..Words.
- Buffer: a GenBitsWidth data register plus a fips_buf_q register.
- Fill: genbits_ready_o = en_i && (cnt_q == 0), which is purely registered state.
  - On handshake: buffer <= genbits_i, fips_buf_q <= genbits_fips_i, cnt_q <= Words.
- Serve: a request is taken when edn_req && en_i && cnt_q != 0 && !edn_ack_q.
  - Next cycle: edn_ack = 1 for exactly one cycle.
  - edn_bus = lowest undelivered word. Word order is bits [31:0] first, then [63:32], and so on.
  - edn_fips = fips_buf_q.
  - cnt_q decrements, and the buffer shifts right by BusWidth (or the read index advances).
- Requests with an empty buffer stall: no ack is generated, and the request stays pending until a block arrives.
- The requester deasserts edn_req in the cycle after edn_ack. The responder ignores edn_req while edn_ack_q = 1, so one request never receives two acks.
- edn_bus and edn_fips hold their last served value until the next ack. They never change without an ack, which satisfies requester-side bus-stability.
- en_i low:
  - cnt_q is cleared to 0, which discards remaining words.
  - genbits_ready_o goes low and no new ack is issued.
  - An ack already registered in the current cycle completes.
  - edn_bus and edn_fips keep their value.
- Re-enable: the block starts empty and needs a fresh entropy block before acking.
- buf_empty_o = (cnt_q == 0).

## Timing
- Reset values:
  - edn_ack = 0, edn_bus = 0, edn_fips = 0.
  - cnt_q = 0, so genbits_ready_o = en_i and buf_empty_o = 1.
  - Buffer = 0, fips_buf_q = 0.
- Request-to-ack latency is 1 cycle when the buffer is non-empty: edn_req sampled high at cycle T gives edn_ack at T+1.
- Maximum throughput is one word per 2 cycles per requester, limited by the request drop.
- Refill:
  - The last word is acked at T+1, so cnt_q = 0 at T+1 and genbits_ready_o = 1 at T+1.
  - A block accepted at T+1 gives cnt_q = Words at T+2.
  - A pending request at T+2 is acked at T+3.
- A block accepted at cycle N can be acked at N+2 at the earliest.
- Simultaneous genbits handshake and request with empty buffer: the block is loaded first, and the request is served the cycle after the load.
- Reset mid-operation clears all state immediately and asynchronously. The ack pulse is aborted, and the bus and fips return to 0.

## Structure
- edn_req_t, edn_rsp_t and ENDPOINT_BUS_WIDTH come from edn_pkg.
- The GenBitsWidth default comes from csrng_pkg::GENBITS_BUS_WIDTH.
- No new package items are needed.
- Single module with no sub-module; the unpack counter and shift register are inline.
- Add an assertion that GenBitsWidth % BusWidth == 0.
- Add an assertion that edn_ack never occurs on two consecutive cycles.

## Test plan
- Reset, then en_i=1 and no block, edn_req held high for 10 cycles -> edn_ack stays 0; buf_empty_o=1; genbits_ready_o=1.
- Block 0x44444444_33333333_22222222_11111111 with fips=1, then 4 requests -> acks carry 0x11111111, 0x22222222, 0x33333333, 0x44444444, each with edn_fips=1; then buf_empty_o=1.
- Block A (fips=0) followed by block B (fips=1), 8 requests -> the first 4 words have edn_fips=0 and the last 4 have edn_fips=1; genbits_ready_o is low until A's 4th ack.
- edn_req held high for 1 extra cycle after each ack -> exactly one ack per request, no skipped or duplicated words.
- en_i dropped after 2 of 4 words -> cnt_q=0 and no further ack; after re-enable plus a new block, the first ack carries word 0 of the new block; edn_bus holds its prior word meanwhile.
- Assert rst_ni during an ack pulse -> edn_ack, edn_bus and edn_fips go to 0 immediately; buf_empty_o=1.
